// File: rtl/dpd_pkg.sv
// Shared constants, width helper and config bundle
// for the runtime-programmable pattern detector.
package dpd_pkg;

  localparam int DPD_MAX_LEN = 8;
  localparam int DPD_CNT_W   = 8;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int DPD_LEN_W = len_w(DPD_MAX_LEN);

  localparam logic [DPD_MAX_LEN-1:0] DPD_DEF_PATTERN = 8'b0001_0110;
  localparam int                     DPD_DEF_LEN     = 5;
  localparam logic                   DPD_DEF_OVERLAP = 1'b0;

  typedef struct packed {
    logic [DPD_MAX_LEN-1:0] pattern;
    logic [DPD_LEN_W-1:0]   len;
    logic                   overlap;
  } dpd_cfg_t;

endpackage

// File: rtl/dpd_window.sv
// Serial history, fill counter and length-masked compare.
// hit is combinational and only asserted on a data beat.
module dpd_window
  import dpd_pkg::*;
#(
  parameter int MAX_LEN = DPD_MAX_LEN,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               beat,
  input  logic               data_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit
);

  localparam logic [LEN_W:0]   ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

  // The oldest bit never reaches a compare, so it is not stored.
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_p1;
  logic [LEN_W-1:0]   fill_sat;
  logic               enough;
  logic               eq;

  assign win     = {hist, data_in};
  assign fill_p1 = {1'b0, fill} + ONE;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign fill_sat = (fill == FULL) ? fill : fill_p1[LEN_W-1:0];
  assign enough   = (fill_p1 >= {1'b0, len});
  assign eq       = (((win ^ pattern) & mask) == '0);
  assign hit      = beat && enough && eq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (beat) begin
      hist <= win[MAX_LEN-2:0];
      if (hit && !overlap) fill <= '0;
      else                 fill <= fill_sat;
    end
  end

endmodule

// File: rtl/dyn_pattern_det.sv
// Programmable serial pattern detector: config register,
// error flag, saturating match counter and output pulse.
module dyn_pattern_det
  import dpd_pkg::*;
#(
  parameter int                 MAX_LEN     = DPD_MAX_LEN,
  parameter int                 CNT_W       = DPD_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DPD_DEF_PATTERN),
  parameter int                 DEF_LEN     = DPD_DEF_LEN,
  parameter logic               DEF_OVERLAP = DPD_DEF_OVERLAP,
  parameter int                 LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               pattern_det,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic [LEN_W-1:0]   cur_len
);

  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{
    pattern: DEF_PATTERN,
    len:     LEN_W'(DEF_LEN),
    overlap: DEF_OVERLAP
  };

  cfg_t cfg;
  logic len_ok;
  logic load;
  logic beat;
  logic hit;

  assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign load   = cfg_load && len_ok;
  // A legal load drops any coincident data bit.
  assign beat   = data_valid && !load;

  dpd_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .clr     (load),
    .beat    (beat),
    .data_in (data_in),
    .pattern (cfg.pattern),
    .len     (cfg.len),
    .overlap (cfg.overlap),
    .hit     (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg     <= DEF_CFG;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      cfg_err <= !len_ok;
      if (len_ok) begin
        cfg <= '{pattern: cfg_pattern,
                 len:     cfg_len,
                 overlap: cfg_overlap};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_det <= 1'b0;
      match_count <= '0;
    end else begin
      pattern_det <= hit;
      if (cnt_clr) begin
        match_count <= '0;
      end else if (hit && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

  assign cur_len = cfg.len;

endmodule

// File: tb/tb_dyn_pattern_det.sv
// Directed bench for dyn_pattern_det (MAX_LEN=8, CNT_W=4)
// with immediate-assertion checks at each step.
module tb_dyn_pattern_det;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       data_valid;
  logic       data_in;
  logic       pattern_det;
  logic [3:0] match_count;
  logic       cfg_err;
  logic [3:0] cur_len;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dyn_pattern_det #(
    .MAX_LEN (8),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .data_valid  (data_valid),
    .data_in     (data_in),
    .pattern_det (pattern_det),
    .match_count (match_count),
    .cfg_err     (cfg_err),
    .cur_len     (cur_len)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic d, input logic ld,
                     input logic clr, input logic [7:0] pat,
                     input logic [3:0] len, input logic ovl);
    @(negedge clk);
    data_valid  = v;
    data_in     = d;
    cfg_load    = ld;
    cnt_clr     = clr;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    @(posedge clk);
    #1;
  endtask

  task automatic bt(input string tag, input logic d, input logic exp);
    cyc(1'b1, d, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    chk(tag, {31'd0, pattern_det}, {31'd0, exp});
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    chk(tag, {31'd0, pattern_det}, 32'd0);
  endtask

  task automatic ld(input logic [7:0] pat, input logic [3:0] len,
                    input logic ovl);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, pat, len, ovl);
    chk("load_det", {31'd0, pattern_det}, 32'd0);
  endtask

  initial begin
    bit s1[10] = '{1, 0, 1, 1, 0, 1, 0, 1, 1, 0};
    bit e1[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit s2[7]  = '{1, 0, 1, 1, 0, 1, 1};
    bit e2o[7] = '{0, 0, 0, 1, 0, 0, 1};
    bit e2n[7] = '{0, 0, 0, 1, 0, 0, 0};
    bit s3[4]  = '{1, 0, 1, 1};

    rst = 1'b0;
    cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cnt_clr = 1'b0;
    data_valid = 1'b0; data_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_det", {31'd0, pattern_det}, 32'd0);
    chk("rst_cnt", {28'd0, match_count}, 32'd0);
    chk("rst_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_len", {28'd0, cur_len}, 32'd5);
    @(negedge clk);
    rst = 1'b1;

    // default 10110, non-overlap
    for (int i = 0; i < 10; i++)
      bt($sformatf("t1_beat%0d", i + 1), s1[i], e1[i]);
    chk("t1_cnt", {28'd0, match_count}, 32'd2);
    chk("t1_len", {28'd0, cur_len}, 32'd5);

    // 1011 overlap, then non-overlap
    ld(8'h0B, 4'd4, 1'b1);
    chk("t2_len", {28'd0, cur_len}, 32'd4);
    for (int i = 0; i < 7; i++)
      bt($sformatf("t2o_beat%0d", i + 1), s2[i], e2o[i]);
    chk("t2o_cnt", {28'd0, match_count}, 32'd4);
    ld(8'h0B, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++)
      bt($sformatf("t2n_beat%0d", i + 1), s2[i], e2n[i]);
    chk("t2n_cnt", {28'd0, match_count}, 32'd5);

    // gaps between every bit
    ld(8'h0B, 4'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bt($sformatf("t3_beat%0d", i + 1), s3[i], (i == 3));
      for (int g = 0; g < 3; g++)
        idle($sformatf("t3_gap%0d_%0d", i + 1, g));
    end
    chk("t3_cnt", {28'd0, match_count}, 32'd6);

    // illegal lengths keep old config
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 4'd0, 1'b1);
    chk("t4_err0", {31'd0, cfg_err}, 32'd1);
    chk("t4_len0", {28'd0, cur_len}, 32'd4);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 4'd9, 1'b1);
    chk("t4_err9", {31'd0, cfg_err}, 32'd1);
    chk("t4_det9", {31'd0, pattern_det}, 32'd0);
    bt("t4_beat2", 1'b0, 1'b0);
    bt("t4_beat3", 1'b1, 1'b0);
    bt("t4_beat4", 1'b1, 1'b1);
    chk("t4_cnt", {28'd0, match_count}, 32'd7);
    ld(8'h01, 4'd1, 1'b0);
    chk("t4_errclr", {31'd0, cfg_err}, 32'd0);
    chk("t4_len1", {28'd0, cur_len}, 32'd1);

    // len=1 saturation and clear-wins
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0);
    chk("t5_clr", {28'd0, match_count}, 32'd0);
    for (int i = 0; i < 20; i++)
      bt($sformatf("t5_beat%0d", i + 1), 1'b1, 1'b1);
    chk("t5_sat", {28'd0, match_count}, 32'd15);
    bt("t5_zero", 1'b0, 1'b0);
    chk("t5_hold", {28'd0, match_count}, 32'd15);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0);
    chk("t5_clrhit_det", {31'd0, pattern_det}, 32'd1);
    chk("t5_clrhit_cnt", {28'd0, match_count}, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 4'd1, 1'b1);
    chk("t5_drop_det", {31'd0, pattern_det}, 32'd0);
    chk("t5_drop_cnt", {28'd0, match_count}, 32'd0);

    // reset mid-stream
    ld(8'h16, 4'd5, 1'b0);
    bt("t6_pre1", 1'b1, 1'b0);
    bt("t6_pre2", 1'b0, 1'b0);
    bt("t6_pre3", 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 4'd0, 1'b1);
    chk("t6_err_pre", {31'd0, cfg_err}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    cfg_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rst_det", {31'd0, pattern_det}, 32'd0);
    chk("t6_rst_err", {31'd0, cfg_err}, 32'd0);
    chk("t6_rst_len", {28'd0, cur_len}, 32'd5);
    @(negedge clk);
    rst = 1'b1;
    bt("t6_post1", 1'b1, 1'b0);
    bt("t6_post2", 1'b0, 1'b0);
    bt("t6_post3", 1'b1, 1'b0);
    bt("t6_post4", 1'b1, 1'b0);
    bt("t6_post5", 1'b0, 1'b1);
    chk("t6_cnt", {28'd0, match_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dyn_pattern_det.md
Name: dyn_pattern_det

Overview:
- Runtime-programmable serial bit-pattern detector. It is the parametrised successor to the team's fixed 5-bit sequence detector.
- Pattern length (1..MAX_LEN), pattern value and overlap/non-overlap mode are loaded through a config strobe.
- Adds a data-valid qualifier, a saturating match counter and config-error flagging.
- Sits on the serial data path; pattern_det feeds downstream framing/alarm logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of match_count.
- DEF_PATTERN, 8'b0001_0110, reset pattern (LSB-aligned, MAX_LEN bits wide).
- DEF_LEN, 5, reset pattern length (1..MAX_LEN).
- DEF_OVERLAP, 1'b0, reset overlap mode.
- LEN_W, $clog2(MAX_LEN+1), derived, width of length fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_load  in  1  single-cycle config strobe.
- cfg_pattern  in  MAX_LEN  pattern. Bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cnt_clr  in  1  synchronous clear of match_count.
- data_valid  in  1  qualifies data_in.
- data_in  in  1  serial data bit.
- pattern_det  out  1  one-cycle match pulse, registered.
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  sticky: last cfg_load had an illegal length.
- cur_len  out  LEN_W  active pattern length (status).

Behaviour:
- Reset (rst=0, async):
  - pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
  - hist=0, fill=0.
  - pattern_det=0, match_count=0, cfg_err=0, cur_len=DEF_LEN.
- State:
  - hist: MAX_LEN-bit shift register, newest bit at LSB.
  - fill: LEN_W counter of valid bits accumulated since the last clear, saturating at MAX_LEN.
- Data beat (data_valid=1, cfg_load=0), all at the same rising edge:
  - hist <= {hist[MAX_LEN-2:0], data_in}.
  - win = {hist[MAX_LEN-2:0], data_in}.
  - hit = (fill+1 >= len) && (win[len-1:0] == pattern[len-1:0]). Compare only the low len bits; ignore the upper bits of both.
  - hit=1: pattern_det<=1. If overlap=0, fill<=0; otherwise fill<=sat(fill+1).
  - hit=0: fill<=sat(fill+1).
- Latency: pattern_det rises on the edge that samples the final pattern bit and is high for exactly one cycle.
- data_valid=0: hist and fill hold; pattern_det<=0. Gaps in the stream are transparent.
- Config (cfg_load=1):
  - Legal when 1 <= cfg_len <= MAX_LEN. Then load pattern, len and overlap; clear hist and fill; set cfg_err<=0; pattern_det<=0. match_count is untouched.
  - Illegal (0 or >MAX_LEN): config, hist and fill are unchanged; cfg_err<=1; detection continues with the old config. The data beat in that cycle is still processed normally.
  - cfg_load and data_valid in the same cycle with a legal load: config wins and the data bit is dropped.
- match_count:
  - Increments on each hit and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets it to 0; cnt_clr with a simultaneous hit gives 0 (clear wins). pattern_det still pulses.
- len=1: every beat equal to pattern[0] hits, in both modes.
- Reset mid-stream: all partial progress is lost; config returns to the DEF_* values.

Decomposition:
- Package dpd_pkg holds:
  - the MAX_LEN and CNT_W defaults;
  - the LEN_W derivation function;
  - the DEF_* constants;
  - a cfg struct {pattern, len, overlap}.
- Sub-module dpd_window: hist shift register, fill counter and masked compare. It outputs hit and takes a clear input.
- The top level holds the config register, error flag, counter and output register.

Test Plan:
- After reset, default pattern 10110 (non-overlap); stream 1,0,1,1,0,1,0,1,1,0 -> pattern_det pulses at beats 5 and 10; match_count=2; cur_len=5.
- Load pattern 1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 -> det at beats 4 and 7. Reload with overlap=0, same stream -> det at beat 4 only.
- len=4 pattern 1011 with data_valid deasserted for 3 cycles between every bit -> det on beat 4; pattern_det=0 during all gaps.
- cfg_load with cfg_len=0, then cfg_len=9 (MAX_LEN=8) -> cfg_err=1 each time; prior pattern still detects. Next legal load -> cfg_err=0.
- CNT_W=4, len=1 pattern 1, twenty 1s -> match_count saturates at 15. cnt_clr coincident with a hit -> count 0 and pattern_det=1.
- Default config, send 1,0,1, assert rst for 2 cycles, release, send 1,0 -> no det (fill restarted); config back to defaults.
